// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table sweep controller.
//   state_e  : sweep FSM states
//   DEF_*    : default input count and settle interval
//   row_bit  : bit position of a row inside a hex-order truth table
package tt_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_SAMPLE, ST_DONE} state_e;

  localparam int DEF_N_IN   = 3;
  localparam int DEF_SETTLE = 2;

  // Hex order puts row 0 in the MSB, so row idx lives at ROWS-1-idx.
  function automatic int row_bit(input int idx, input int n_in = DEF_N_IN);
    return (1 << n_in) - 1 - idx;
  endfunction

endpackage

// File: rtl/tt_sweep_ctrl_if.sv
// Harness/circuit-facing signal bundle of the sweep controller.
//   master : test harness (+ circuit output dut_out), drives start/abort/expected_tt
//   slave  : tt_sweep_ctrl, drives dut_in and all result signals
interface tt_sweep_ctrl_if
  import tt_pkg::*;
#(parameter int N_IN = DEF_N_IN);
  localparam int ROWS = 1 << N_IN;

  logic              start;
  logic              abort;
  logic [ROWS-1:0]   expected_tt;
  logic [N_IN-1:0]   dut_in;
  logic              dut_out;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ROWS-1:0]   observed_tt;
  logic [N_IN:0]     mismatch_cnt;
  logic              fail_valid;
  logic [N_IN-1:0]   first_fail_idx;

  modport master (
    output start, abort, expected_tt, dut_out,
    input  dut_in, busy, done, pass, observed_tt, mismatch_cnt, fail_valid, first_fail_idx
  );

  modport slave (
    input  start, abort, expected_tt, dut_out,
    output dut_in, busy, done, pass, observed_tt, mismatch_cnt, fail_valid, first_fail_idx
  );
endinterface

// File: rtl/tt_settle_timer.sv
// Settle-interval timer for one row.
//   clk, rst_n : clock, async active-low reset
//   load_i     : reload the interval (first cycle of a row's hold)
//   en_i       : count down while holding
//   expire_o   : interval elapsed; high in the last hold cycle
// A row is held for max(SETTLE_CYCLES,1) cycles, so 0 expires at once.
module tt_settle_timer
  import tt_pkg::*;
#(parameter int SETTLE_CYCLES = DEF_SETTLE)
(
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  logic [CW-1:0] cnt_q;

  assign expire_o = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt_q <= '0;
    else if (load_i)           cnt_q <= LOAD_VAL;
    else if (en_i && !expire_o) cnt_q <= cnt_q - 1'b1;
  end
endmodule

// File: rtl/tt_sweep_ctrl.sv
// Walks a combinational circuit through all 2^N_IN input rows, samples its
// output after a settle interval and scores it against an expected table.
//   clk, rst_n : clock, async active-low reset
//   bus        : tt_sweep_ctrl_if.slave (start/abort/expected_tt/dut_out in;
//                dut_in, busy, done, pass, observed_tt, mismatch_cnt,
//                fail_valid, first_fail_idx out)
module tt_sweep_ctrl
  import tt_pkg::*;
#(
  parameter int N_IN          = DEF_N_IN,
  parameter int SETTLE_CYCLES = DEF_SETTLE
)
(
  input  logic             clk,
  input  logic             rst_n,
  tt_sweep_ctrl_if.slave   bus
);
  localparam int ROWS = 1 << N_IN;
  localparam logic [N_IN-1:0] LAST   = N_IN'(ROWS - 1);
  localparam logic [N_IN:0]   MM_ONE = (N_IN+1)'(1);

  state_e            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [ROWS-1:0]   exp_q, exp_d;
  logic [ROWS-1:0]   obs_q, obs_d;
  logic [N_IN:0]     mm_q, mm_d;
  logic              fv_q, fv_d;
  logic [N_IN-1:0]   ffi_q, ffi_d;
  logic              pass_q, pass_d;
  logic [N_IN-1:0]   rb;
  logic              tmr_load, tmr_exp;

  assign rb = N_IN'(row_bit(int'(idx_q), N_IN));

  // Reload on every entry into HOLD (from IDLE or from the previous row).
  assign tmr_load = (state_d == ST_HOLD) && (state_q != ST_HOLD);

  tt_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (tmr_load),
    .en_i     (state_q == ST_HOLD),
    .expire_o (tmr_exp)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    exp_d   = exp_q;
    obs_d   = obs_q;
    mm_d    = mm_q;
    fv_d    = fv_q;
    ffi_d   = ffi_q;
    pass_d  = pass_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          exp_d   = bus.expected_tt;
          obs_d   = '0;
          mm_d    = '0;
          fv_d    = 1'b0;
          ffi_d   = '0;
          pass_d  = 1'b0;
          idx_d   = '0;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.abort) begin
          idx_d   = '0;
          state_d = ST_IDLE;
        end else if (tmr_exp) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        // Abort wins over the sample: the aborted row is not recorded.
        if (bus.abort) begin
          idx_d   = '0;
          state_d = ST_IDLE;
        end else begin
          obs_d[rb] = bus.dut_out;
          if (bus.dut_out != exp_q[rb]) begin
            mm_d = mm_q + MM_ONE;
            if (!fv_q) begin
              fv_d  = 1'b1;
              ffi_d = idx_q;
            end
          end
          if (idx_q == LAST) begin
            idx_d   = '0;
            pass_d  = (mm_d == '0);
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_HOLD;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      exp_q   <= '0;
      obs_q   <= '0;
      mm_q    <= '0;
      fv_q    <= 1'b0;
      ffi_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      exp_q   <= exp_d;
      obs_q   <= obs_d;
      mm_q    <= mm_d;
      fv_q    <= fv_d;
      ffi_q   <= ffi_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.dut_in         = idx_q;
  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.done           = (state_q == ST_DONE);
  assign bus.pass           = pass_q;
  assign bus.observed_tt    = obs_q;
  assign bus.mismatch_cnt   = mm_q;
  assign bus.fail_valid     = fv_q;
  assign bus.first_fail_idx = ffi_q;
endmodule
